ex_flag_branch: RTL and testbench

- Sits directly downstream of the execute-stage ALU.
- Captures the ALU result and its ov/zr outputs into the architectural flag register (Z, V, N).
- Resolves conditional branches against the committed flags, issues a registered PC redirect, and squashes wrong-path instructions for a fixed number of cycles.
- Also forms the EX/MEM result register for the ALU output.

---
 rtl/ex_flag_branch_pkg.sv | 45 ++++
 rtl/ex_flag_branch_br_cond_eval.sv | 27 ++
 rtl/ex_flag_branch.sv | 178 +++++++++++++++++
 tb/tb_ex_flag_branch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_flag_branch_pkg.sv
// Shared encodings for the EX-stage flag/branch block: ALU op codes, branch
// condition codes, FSM states and the per-op flag-update class.
package ex_flag_branch_pkg;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_NOR = 3'd3;
   localparam logic [2:0] ALU_SLL = 3'd4;
   localparam logic [2:0] ALU_SRL = 3'd5;
   localparam logic [2:0] ALU_SRA = 3'd6;
   localparam logic [2:0] ALU_LHB = 3'd7;

   localparam logic [2:0] BR_NE  = 3'd0;
   localparam logic [2:0] BR_EQ  = 3'd1;
   localparam logic [2:0] BR_GT  = 3'd2;
   localparam logic [2:0] BR_LT  = 3'd3;
   localparam logic [2:0] BR_GE  = 3'd4;
   localparam logic [2:0] BR_LE  = 3'd5;
   localparam logic [2:0] BR_OV  = 3'd6;
   localparam logic [2:0] BR_ALW = 3'd7;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_SQUASH   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FLAG_NONE = 2'd0,
      FLAG_Z    = 2'd1,
      FLAG_ZVN  = 2'd2
   } flag_class_e;

   function automatic flag_class_e flag_class(input logic [2:0] op);
      flag_class_e fc;
      case (op)
         ALU_ADD, ALU_SUB:                            fc = FLAG_ZVN;
         ALU_AND, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA: fc = FLAG_Z;
         default:                                     fc = FLAG_NONE;
      endcase
      return fc;
   endfunction

endpackage

// File: rtl/ex_flag_branch_br_cond_eval.sv
// Combinational branch-condition evaluator: committed flags plus a condition
// code give the taken decision.
module br_cond_eval
   import ex_flag_branch_pkg::*;
(
   input  logic       flag_z,
   input  logic       flag_v,
   input  logic       flag_n,
   input  logic [2:0] br_cond,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (br_cond)
         BR_NE:   taken = ~flag_z;
         BR_EQ:   taken = flag_z;
         BR_GT:   taken = ~flag_z & ~flag_n;
         BR_LT:   taken = flag_n;
         BR_GE:   taken = flag_z | ~flag_n;
         BR_LE:   taken = flag_n | flag_z;
         BR_OV:   taken = flag_v;
         default: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_flag_branch.sv
// EX-stage flag register, branch resolution with registered redirect/squash,
// and EX/MEM result register. Optional branch counters under EXF_BR_PERF_EN.
module ex_flag_branch
   import ex_flag_branch_pkg::*;
#(
   parameter int SQUASH_CYCLES = 2,
   parameter int DW            = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall_i,
   input  logic          ex_valid,
   input  logic [2:0]    alu_op,
   input  logic [DW-1:0] alu_dst,
   input  logic          alu_ov,
   input  logic          alu_zr,
   input  logic          is_branch,
   input  logic [2:0]    br_cond,
   input  logic [DW-1:0] br_target,
   output logic          flag_z,
   output logic          flag_v,
   output logic          flag_n,
   output logic          br_taken,
   output logic [DW-1:0] br_pc,
   output logic          flush,
   output logic [DW-1:0] exm_dst,
`ifdef EXF_BR_PERF_EN
   output logic [15:0]   br_total_cnt,
   output logic [15:0]   br_taken_cnt,
`endif
   output logic          exm_valid
);

   localparam logic [2:0] SQUASH_INIT = 3'(SQUASH_CYCLES - 1);

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          z_q, z_d, v_q, v_d, n_q, n_d;
   logic          br_taken_q, br_taken_d;
   logic          flush_q, flush_d;
   logic [DW-1:0] br_pc_q, br_pc_d;
   logic [DW-1:0] exm_dst_q, exm_dst_d;
   logic          exm_valid_q, exm_valid_d;
   logic          cond_taken;
   logic          accept_br;

   br_cond_eval u_br_cond_eval (
      .flag_z  (z_q),
      .flag_v  (v_q),
      .flag_n  (n_q),
      .br_cond (br_cond),
      .taken   (cond_taken)
   );

   assign accept_br = ~stall_i & ex_valid & is_branch & (state_q == ST_RUN);

   // Everything holds under stall; strobes and exm_valid fall otherwise.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      z_d         = z_q;
      v_d         = v_q;
      n_d         = n_q;
      br_taken_d  = br_taken_q;
      flush_d     = flush_q;
      br_pc_d     = br_pc_q;
      exm_dst_d   = exm_dst_q;
      exm_valid_d = exm_valid_q;
      if (!stall_i) begin
         br_taken_d  = 1'b0;
         flush_d     = 1'b0;
         exm_valid_d = 1'b0;
         case (state_q)
            ST_RUN: begin
               if (ex_valid && is_branch) begin
                  if (cond_taken) begin
                     state_d    = ST_REDIRECT;
                     br_taken_d = 1'b1;
                     flush_d    = 1'b1;
                     br_pc_d    = br_target;
                  end
               end else if (ex_valid) begin
                  exm_valid_d = 1'b1;
                  exm_dst_d   = alu_dst;
                  case (flag_class(alu_op))
                     FLAG_ZVN: begin
                        z_d = alu_zr;
                        v_d = alu_ov;
                        n_d = alu_dst[DW-1];
                     end
                     FLAG_Z:  z_d = alu_zr;
                     default: ;
                  endcase
               end
            end
            ST_REDIRECT: begin
               if (SQUASH_CYCLES == 1) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_SQUASH;
                  cnt_d   = SQUASH_INIT;
               end
            end
            ST_SQUASH: begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q <= 3'd1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= 3'd0;
         z_q         <= 1'b0;
         v_q         <= 1'b0;
         n_q         <= 1'b0;
         br_taken_q  <= 1'b0;
         flush_q     <= 1'b0;
         br_pc_q     <= '0;
         exm_dst_q   <= '0;
         exm_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         z_q         <= z_d;
         v_q         <= v_d;
         n_q         <= n_d;
         br_taken_q  <= br_taken_d;
         flush_q     <= flush_d;
         br_pc_q     <= br_pc_d;
         exm_dst_q   <= exm_dst_d;
         exm_valid_q <= exm_valid_d;
      end
   end

`ifdef EXF_BR_PERF_EN
   logic [15:0] br_total_cnt_q, br_total_cnt_d;
   logic [15:0] br_taken_cnt_q, br_taken_cnt_d;

   always_comb begin
      br_total_cnt_d = br_total_cnt_q;
      br_taken_cnt_d = br_taken_cnt_q;
      if (accept_br && br_total_cnt_q != 16'hFFFF)
         br_total_cnt_d = br_total_cnt_q + 16'd1;
      if (accept_br && cond_taken && br_taken_cnt_q != 16'hFFFF)
         br_taken_cnt_d = br_taken_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_total_cnt_q <= 16'd0;
         br_taken_cnt_q <= 16'd0;
      end else begin
         br_total_cnt_q <= br_total_cnt_d;
         br_taken_cnt_q <= br_taken_cnt_d;
      end
   end

   assign br_total_cnt = br_total_cnt_q;
   assign br_taken_cnt = br_taken_cnt_q;
`else
   logic unused_accept_br;
   assign unused_accept_br = accept_br;
`endif

   assign flag_z    = z_q;
   assign flag_v    = v_q;
   assign flag_n    = n_q;
   assign br_taken  = br_taken_q;
   assign flush     = flush_q;
   assign br_pc     = br_pc_q;
   assign exm_dst   = exm_dst_q;
   assign exm_valid = exm_valid_q;

endmodule

// File: tb/tb_ex_flag_branch.sv
// Directed, table-driven bench for ex_flag_branch (SQUASH_CYCLES=2, DW=16),
// plus hand-written reset-abort and counter-saturation sequences.
module tb_ex_flag_branch;
   import ex_flag_branch_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        ex_valid;
   logic [2:0]  alu_op;
   logic [15:0] alu_dst;
   logic        alu_ov;
   logic        alu_zr;
   logic        is_branch;
   logic [2:0]  br_cond;
   logic [15:0] br_target;
   logic        flag_z, flag_v, flag_n;
   logic        br_taken;
   logic [15:0] br_pc;
   logic        flush;
   logic [15:0] exm_dst;
   logic        exm_valid;
`ifdef EXF_BR_PERF_EN
   logic [15:0] br_total_cnt;
   logic [15:0] br_taken_cnt;
`endif

   int testsRun  = 0;
   int failCount = 0;

   ex_flag_branch #(.SQUASH_CYCLES(2), .DW(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall_i),
      .ex_valid     (ex_valid),
      .alu_op       (alu_op),
      .alu_dst      (alu_dst),
      .alu_ov       (alu_ov),
      .alu_zr       (alu_zr),
      .is_branch    (is_branch),
      .br_cond      (br_cond),
      .br_target    (br_target),
      .flag_z       (flag_z),
      .flag_v       (flag_v),
      .flag_n       (flag_n),
      .br_taken     (br_taken),
      .br_pc        (br_pc),
      .flush        (flush),
      .exm_dst      (exm_dst),
`ifdef EXF_BR_PERF_EN
      .br_total_cnt (br_total_cnt),
      .br_taken_cnt (br_taken_cnt),
`endif
      .exm_valid    (exm_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        ev;
      logic        br;
      logic [2:0]  op;
      logic [15:0] dst;
      logic        ov;
      logic        zr;
      logic [2:0]  cond;
      logic [15:0] tgt;
      logic        ez, evf, en, ebt, efl;
      logic [15:0] epc;
      logic        eev;
      logic [15:0] eed;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic stall, ev, br, input logic [2:0] op,
                               input logic [15:0] dst, input logic ov, zr,
                               input logic [2:0] cond, input logic [15:0] tgt,
                               input logic ez, evf, en, ebt, efl,
                               input logic [15:0] epc, input logic eev,
                               input logic [15:0] eed);
      vec_t v;
      v.stall = stall; v.ev = ev; v.br = br; v.op = op; v.dst = dst;
      v.ov = ov; v.zr = zr; v.cond = cond; v.tgt = tgt;
      v.ez = ez; v.evf = evf; v.en = en; v.ebt = ebt; v.efl = efl;
      v.epc = epc; v.eev = eev; v.eed = eed;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      stall_i   = v.stall;
      ex_valid  = v.ev;
      is_branch = v.br;
      alu_op    = v.op;
      alu_dst   = v.dst;
      alu_ov    = v.ov;
      alu_zr    = v.zr;
      br_cond   = v.cond;
      br_target = v.tgt;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkVector(input int idx, input vec_t v);
      checkOutput($sformatf("v%0d flag_z", idx),    16'(flag_z),    16'(v.ez));
      checkOutput($sformatf("v%0d flag_v", idx),    16'(flag_v),    16'(v.evf));
      checkOutput($sformatf("v%0d flag_n", idx),    16'(flag_n),    16'(v.en));
      checkOutput($sformatf("v%0d br_taken", idx),  16'(br_taken),  16'(v.ebt));
      checkOutput($sformatf("v%0d flush", idx),     16'(flush),     16'(v.efl));
      checkOutput($sformatf("v%0d br_pc", idx),     br_pc,          v.epc);
      checkOutput($sformatf("v%0d exm_valid", idx), 16'(exm_valid), 16'(v.eev));
      checkOutput($sformatf("v%0d exm_dst", idx),   exm_dst,        v.eed);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Columns: stall ev br op dst ov zr cond tgt | Z V N br_taken flush br_pc exm_valid exm_dst
   initial begin
      vecs.push_back(mk(0,1,0,ALU_ADD,16'h7FFF,1,0,BR_NE ,16'h0000, 0,1,0,0,0,16'h0000,1,16'h7FFF));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_EQ ,16'h0010, 0,1,0,0,0,16'h0000,0,16'h7FFF));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_GT ,16'h0020, 0,1,0,1,1,16'h0020,0,16'h7FFF));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_OV ,16'h0040, 0,1,0,0,0,16'h0020,0,16'h7FFF));
      vecs.push_back(mk(0,1,0,ALU_ADD,16'h0000,0,1,BR_NE ,16'h0000, 0,1,0,0,0,16'h0020,0,16'h7FFF));
      vecs.push_back(mk(0,1,0,ALU_ADD,16'h0000,0,1,BR_NE ,16'h0000, 1,0,0,0,0,16'h0020,1,16'h0000));
      vecs.push_back(mk(0,1,0,ALU_ADD,16'h7FFF,1,0,BR_NE ,16'h0000, 0,1,0,0,0,16'h0020,1,16'h7FFF));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_OV ,16'h0040, 0,1,0,1,1,16'h0040,0,16'h7FFF));
      vecs.push_back(mk(0,0,0,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0000, 0,1,0,0,0,16'h0040,0,16'h7FFF));
      vecs.push_back(mk(0,0,0,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0000, 0,1,0,0,0,16'h0040,0,16'h7FFF));
      vecs.push_back(mk(0,1,0,ALU_SUB,16'h8000,0,0,BR_NE ,16'h0000, 0,0,1,0,0,16'h0040,1,16'h8000));
      vecs.push_back(mk(0,1,0,ALU_AND,16'h0000,0,1,BR_NE ,16'h0000, 1,0,1,0,0,16'h0040,1,16'h0000));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0050, 1,0,1,0,0,16'h0040,0,16'h0000));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_LT ,16'h0100, 1,0,1,1,1,16'h0100,0,16'h0000));
      vecs.push_back(mk(0,1,0,ALU_ADD,16'h0000,1,1,BR_NE ,16'h0000, 1,0,1,0,0,16'h0100,0,16'h0000));
      vecs.push_back(mk(0,1,0,ALU_ADD,16'h0000,1,1,BR_NE ,16'h0000, 1,0,1,0,0,16'h0100,0,16'h0000));
      vecs.push_back(mk(0,1,0,ALU_LHB,16'h1234,0,0,BR_NE ,16'h0000, 1,0,1,0,0,16'h0100,1,16'h1234));
      vecs.push_back(mk(0,1,0,ALU_SRA,16'hFFFE,1,0,BR_NE ,16'h0000, 0,0,1,0,0,16'h0100,1,16'hFFFE));
      vecs.push_back(mk(1,1,0,ALU_ADD,16'h0000,1,1,BR_NE ,16'h0000, 0,0,1,0,0,16'h0100,1,16'hFFFE));
      vecs.push_back(mk(0,0,0,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0000, 0,0,1,0,0,16'h0100,0,16'hFFFE));
      vecs.push_back(mk(0,0,1,ALU_ADD,16'h0000,0,0,BR_ALW,16'h0500, 0,0,1,0,0,16'h0100,0,16'hFFFE));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_LE ,16'h0200, 0,0,1,1,1,16'h0200,0,16'hFFFE));
      vecs.push_back(mk(1,1,1,ALU_ADD,16'h0000,0,0,BR_ALW,16'h0600, 0,0,1,1,1,16'h0200,0,16'hFFFE));
      vecs.push_back(mk(1,1,1,ALU_ADD,16'h0000,0,0,BR_ALW,16'h0600, 0,0,1,1,1,16'h0200,0,16'hFFFE));
      vecs.push_back(mk(1,1,1,ALU_ADD,16'h0000,0,0,BR_ALW,16'h0600, 0,0,1,1,1,16'h0200,0,16'hFFFE));
      vecs.push_back(mk(0,0,0,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0000, 0,0,1,0,0,16'h0200,0,16'hFFFE));
      vecs.push_back(mk(0,1,0,ALU_ADD,16'h0000,0,1,BR_NE ,16'h0000, 0,0,1,0,0,16'h0200,0,16'hFFFE));
      vecs.push_back(mk(0,1,0,ALU_ADD,16'h0000,0,1,BR_NE ,16'h0000, 1,0,0,0,0,16'h0200,1,16'h0000));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_GE ,16'h0300, 1,0,0,1,1,16'h0300,0,16'h0000));
      vecs.push_back(mk(0,0,0,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0000, 1,0,0,0,0,16'h0300,0,16'h0000));
      vecs.push_back(mk(0,0,0,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0000, 1,0,0,0,0,16'h0300,0,16'h0000));
      vecs.push_back(mk(0,1,1,ALU_ADD,16'h0000,0,0,BR_ALW,16'h0400, 1,0,0,1,1,16'h0400,0,16'h0000));
      vecs.push_back(mk(0,0,0,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0000, 1,0,0,0,0,16'h0400,0,16'h0000));
      vecs.push_back(mk(0,0,0,ALU_ADD,16'h0000,0,0,BR_NE ,16'h0000, 1,0,0,0,0,16'h0400,0,16'h0000));

      rst_n = 1'b0;
      applyStimulus(mk(0,0,0,ALU_ADD,16'h0,0,0,BR_NE,16'h0, 0,0,0,0,0,16'h0,0,16'h0));
      repeat (2) @(posedge clk);
      #1;
      checkVector(-1, mk(0,0,0,ALU_ADD,16'h0,0,0,BR_NE,16'h0, 0,0,0,0,0,16'h0,0,16'h0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         stepCycle();
         checkVector(i, vecs[i]);
      end

`ifdef EXF_BR_PERF_EN
      checkOutput("perf total after table", br_total_cnt, 16'd8);
      checkOutput("perf taken after table", br_taken_cnt, 16'd6);
`endif

      // Reset asserted while the FSM sits in SQUASH must clear everything at once.
      applyStimulus(mk(0,1,1,ALU_ADD,16'h0,0,0,BR_ALW,16'h0700, 0,0,0,0,0,16'h0,0,16'h0));
      stepCycle();
      checkOutput("rst seq br_taken", 16'(br_taken), 16'd1);
      checkOutput("rst seq br_pc", br_pc, 16'h0700);
      applyStimulus(mk(0,0,0,ALU_ADD,16'h0,0,0,BR_NE,16'h0, 0,0,0,0,0,16'h0,0,16'h0));
      stepCycle();
      #2;
      rst_n = 1'b0;
      #1;
      checkVector(100, mk(0,0,0,ALU_ADD,16'h0,0,0,BR_NE,16'h0, 0,0,0,0,0,16'h0,0,16'h0));
`ifdef EXF_BR_PERF_EN
      checkOutput("perf total reset", br_total_cnt, 16'd0);
      checkOutput("perf taken reset", br_taken_cnt, 16'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(mk(0,1,0,ALU_ADD,16'h0003,0,0,BR_NE,16'h0, 0,0,0,0,0,16'h0,0,16'h0));
      stepCycle();
      checkOutput("post-reset exm_valid", 16'(exm_valid), 16'd1);
      checkOutput("post-reset exm_dst", exm_dst, 16'h0003);
      checkOutput("post-reset flag_z", 16'(flag_z), 16'd0);

`ifdef EXF_BR_PERF_EN
      // Z=0 here, so EQ branches are accepted but never taken.
      applyStimulus(mk(0,1,1,ALU_ADD,16'h0,0,0,BR_EQ,16'h0, 0,0,0,0,0,16'h0,0,16'h0));
      repeat (65540) @(posedge clk);
      #1;
      checkOutput("perf total saturate", br_total_cnt, 16'hFFFF);
      checkOutput("perf taken no-take", br_taken_cnt, 16'd0);
      checkOutput("sat br_taken", 16'(br_taken), 16'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
